// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide/accumulate unit.
// Holds the op encodings that the execute stage decodes, the FSM state
// encodings, and the MUL_STEP legality check.
package muldiv_pkg;

  localparam logic [2:0] MULDIV_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_DIV   = 3'd2;
  localparam logic [2:0] MULDIV_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_MADD  = 3'd4;
  localparam logic [2:0] MULDIV_MADDU = 3'd5;
  localparam logic [2:0] MULDIV_MSUB  = 3'd6;
  localparam logic [2:0] MULDIV_MSUBU = 3'd7;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Bit n set means n multiplier bits per cycle is supported (1, 2, 4).
  localparam int MUL_STEP_LEGAL_MASK = 'b10110;

  function automatic bit mul_step_legal(input int width, input int step);
    return (step >= 1) && (step <= 4) && MUL_STEP_LEGAL_MASK[step] &&
           (width >= 8) && (width % 2 == 0) && (width % step == 0);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring radix-2 division step (combinational).
//   part_rem : {partial remainder, next dividend bit}, WIDTH+1 bits
//   divisor  : divisor magnitude
//   rem_next : remainder after the trial subtraction
//   q_bit    : quotient bit (1 when the subtraction did not borrow)
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // part_rem < 2*divisor always holds, so a non-borrowing result fits WIDTH bits.
  assign diff     = part_rem - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply / divide / multiply-accumulate unit for the execute stage.
//   clk, rst          : clock (rising edge), async active-low reset
//   start_in, op_in   : request and op code, sampled only in IDLE
//   src1_in, src2_in  : multiplicand/dividend, multiplier/divisor
//   hi_in, lo_in      : forwarded HI/LO, latched with start (MADD/MSUB)
//   annul_in          : flush, aborts an operation in flight
//   busy_out          : MUL/DIV/ACC in progress (stall request)
//   ready_out         : one-cycle completion pulse (DONE state)
//   hi_out, lo_out    : result high/low, remainder/quotient
//   div_by_zero_out   : divide-by-zero flag, valid with ready_out
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] src1_in,
  input  logic [WIDTH-1:0] src2_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             annul_in,
  output logic             busy_out,
  output logic             ready_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero_out
);

  // An unsupported step size degrades to one bit per cycle rather than
  // building a broken datapath.
  localparam int STEP = mul_step_legal(WIDTH, MUL_STEP) ? MUL_STEP : 1;
  localparam int CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / STEP - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  logic [2:0]         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_lat, lo_lat;
  logic               sgn1_q, sgn2_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // Accept-time operand conditioning; op bit 0 clear means signed.
  logic             signed_in, is_div_in;
  logic [WIDTH-1:0] abs1, abs2;

  assign signed_in = ~op_in[0];
  assign is_div_in = (op_in == MULDIV_DIV) || (op_in == MULDIV_DIVU);
  assign abs1      = (signed_in & src1_in[WIDTH-1]) ? -src1_in : src1_in;
  assign abs2      = (signed_in & src2_in[WIDTH-1]) ? -src2_in : src2_in;

  logic res_neg, rem_neg;
  assign res_neg = ~op_q[0] & (sgn1_q ^ sgn2_q);
  assign rem_neg = ~op_q[0] & sgn1_q;

  // Multiply: acc = {partial sum, remaining multiplier bits}. Each cycle
  // adds multiplicand * (low STEP bits) into the upper half and shifts right.
  logic [WIDTH+STEP-1:0] mul_sum;
  logic [2*WIDTH-1:0]    p_nxt, p_fin;

  always_comb begin
    mul_sum = {{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]};
    for (int j = 0; j < STEP; j++)
      if (acc[j]) mul_sum = mul_sum + ({{STEP{1'b0}}, a_q} << j);
  end

  assign p_nxt = {mul_sum, acc[WIDTH-1:STEP]};
  assign p_fin = res_neg ? -p_nxt : p_nxt;

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0]   d_quo, d_rem, quo_fin, rem_fin;

  div_iter_step #(.WIDTH(WIDTH)) u_div_step (
    .part_rem ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
    .divisor  (b_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign d_nxt   = {rem_next, acc[WIDTH-2:0], q_bit};
  assign d_quo   = d_nxt[WIDTH-1:0];
  assign d_rem   = d_nxt[2*WIDTH-1:WIDTH];
  // MIN / -1 needs no special case: magnitudes give quotient 2^(W-1) with
  // equal signs, which is MIN itself, and remainder 0.
  assign quo_fin = res_neg ? -d_quo : d_quo;
  assign rem_fin = rem_neg ? -d_rem : d_rem;

  logic [2*WIDTH-1:0] acc_res;
  assign acc_res = op_q[1] ? ({hi_lat, lo_lat} - acc) : (acc + {hi_lat, lo_lat});

  assign busy_out  = (state == S_MUL) || (state == S_DIV) || (state == S_ACC);
  assign ready_out = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      op_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      hi_lat          <= '0;
      lo_lat          <= '0;
      sgn1_q          <= 1'b0;
      sgn2_q          <= 1'b0;
      acc             <= '0;
      cnt             <= '0;
      hi_out          <= '0;
      lo_out          <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in && !annul_in) begin
            op_q   <= op_in;
            a_q    <= abs1;
            b_q    <= abs2;
            sgn1_q <= src1_in[WIDTH-1];
            sgn2_q <= src2_in[WIDTH-1];
            hi_lat <= hi_in;
            lo_lat <= lo_in;
            if (is_div_in) begin
              if (src2_in == '0) begin
                // Divide by zero completes at the accept edge.
                state           <= S_DONE;
                hi_out          <= src1_in;
                lo_out          <= '1;
                div_by_zero_out <= 1'b1;
              end else begin
                state <= S_DIV;
                acc   <= {{WIDTH{1'b0}}, abs1};
                cnt   <= DIV_LAST;
              end
            end else begin
              state <= S_MUL;
              acc   <= {{WIDTH{1'b0}}, abs2};
              cnt   <= MUL_LAST;
            end
          end
        end
        S_MUL: begin
          if (annul_in) state <= S_IDLE;
          else begin
            cnt <= cnt - 1'b1;
            acc <= (cnt == '0) ? p_fin : p_nxt;
            if (cnt == '0) begin
              if (op_q[2]) state <= S_ACC;
              else begin
                state           <= S_DONE;
                {hi_out, lo_out} <= p_fin;
                div_by_zero_out <= 1'b0;
              end
            end
          end
        end
        S_DIV: begin
          if (annul_in) state <= S_IDLE;
          else begin
            cnt <= cnt - 1'b1;
            acc <= d_nxt;
            if (cnt == '0) begin
              state           <= S_DONE;
              hi_out          <= rem_fin;
              lo_out          <= quo_fin;
              div_by_zero_out <= 1'b0;
            end
          end
        end
        S_ACC: begin
          if (annul_in) state <= S_IDLE;
          else begin
            state            <= S_DONE;
            {hi_out, lo_out} <= acc_res;
            div_by_zero_out  <= 1'b0;
          end
        end
        // DONE is committed: the pulse is emitted and the unit returns to IDLE
        // whether or not annul_in is raised.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed self-checking bench for muldiv_iter_unit. Three instances share
// the stimulus (MUL_STEP = 2, 1, 4); the default instance is checked in every
// scenario, the other two for multiply latency.
module tb_muldiv_iter_unit;
  import muldiv_pkg::*;

  logic        clk, rst, start, annul;
  logic [2:0]  op;
  logic [31:0] src1, src2, hi_i, lo_i;

  logic        busy2, ready2, dbz2, busy1, ready1, dbz1, busy4, ready4, dbz4;
  logic [31:0] hi2, lo2, hi1, lo1, hi4, lo4;

  int vectors = 0;
  int miscompares = 0;

  muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .start_in(start), .op_in(op), .src1_in(src1), .src2_in(src2),
    .hi_in(hi_i), .lo_in(lo_i), .annul_in(annul), .busy_out(busy2), .ready_out(ready2),
    .hi_out(hi2), .lo_out(lo2), .div_by_zero_out(dbz2));

  muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start_in(start), .op_in(op), .src1_in(src1), .src2_in(src2),
    .hi_in(hi_i), .lo_in(lo_i), .annul_in(annul), .busy_out(busy1), .ready_out(ready1),
    .hi_out(hi1), .lo_out(lo1), .div_by_zero_out(dbz1));

  muldiv_iter_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start_in(start), .op_in(op), .src1_in(src1), .src2_in(src2),
    .hi_in(hi_i), .lo_in(lo_i), .annul_in(annul), .busy_out(busy4), .ready_out(ready4),
    .hi_out(hi4), .lo_out(lo4), .div_by_zero_out(dbz4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a request so that the next rising edge is the accept edge; returns
  // #1 after that edge, i.e. early in cycle 1.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    op = o; src1 = a; src2 = b; hi_i = h; lo_i = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for ready2, starting in cycle 'from'; lat = -1 on timeout.
  task automatic wait_ready(input int from, output int lat, output int nbusy,
                            output logic busy_at_ready);
    lat = -1; nbusy = 0; busy_at_ready = 1'bx;
    for (int k = from; k < from + 200; k++) begin
      @(negedge clk);
      if (ready2 === 1'b1) begin
        lat = k; busy_at_ready = busy2;
        break;
      end
      if (busy2 === 1'b1) nbusy++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy2); end
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready2); end
    vectors++; if (hi2 !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi2); end
    vectors++; if (lo2 !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo2); end
    vectors++; if (dbz2 !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", dbz2); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_mult;
    int lat, nb; logic bd;
    start_op(MULDIV_MULT, 32'hFFFFFFFD, 32'h5, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL mult_latency got %0d want 17", lat); end
    vectors++; if (nb !== 16) begin miscompares++; $display("FAIL mult_busy_cycles got %0d want 16", nb); end
    vectors++; if (bd !== 1'b0) begin miscompares++; $display("FAIL mult_busy_in_done got %b want 0", bd); end
    vectors++; if (hi2 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got %h want FFFFFFFF", hi2); end
    vectors++; if (lo2 !== 32'hFFFFFFF1) begin miscompares++; $display("FAIL mult_lo got %h want FFFFFFF1", lo2); end
    @(negedge clk);
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL mult_ready_width got %b want 0", ready2); end
  endtask

  task automatic test_div_by_zero;
    int lat, nb; logic bd;
    start_op(MULDIV_DIVU, 32'h5, 32'h0, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divz_latency got %0d want 1", lat); end
    vectors++; if (lo2 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL divz_lo got %h want FFFFFFFF", lo2); end
    vectors++; if (hi2 !== 32'h5) begin miscompares++; $display("FAIL divz_hi got %h want 00000005", hi2); end
    vectors++; if (dbz2 !== 1'b1) begin miscompares++; $display("FAIL divz_flag got %b want 1", dbz2); end
    start_op(MULDIV_DIV, 32'hFFFFFFFB, 32'h0, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divz_s_latency got %0d want 1", lat); end
    vectors++; if (hi2 !== 32'hFFFFFFFB) begin miscompares++; $display("FAIL divz_s_hi got %h want FFFFFFFB", hi2); end
    vectors++; if (dbz2 !== 1'b1) begin miscompares++; $display("FAIL divz_s_flag got %b want 1", dbz2); end
  endtask

  task automatic test_div;
    int lat, nb; logic bd;
    start_op(MULDIV_DIV, 32'h7, 32'hFFFFFFFE, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div_latency got %0d want 33", lat); end
    vectors++; if (lo2 !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_quo got %h want FFFFFFFD", lo2); end
    vectors++; if (hi2 !== 32'h1) begin miscompares++; $display("FAIL div_rem got %h want 00000001", hi2); end
    vectors++; if (dbz2 !== 1'b0) begin miscompares++; $display("FAIL div_flag got %b want 0", dbz2); end
    start_op(MULDIV_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lo2 !== 32'h80000000) begin miscompares++; $display("FAIL div_min_quo got %h want 80000000", lo2); end
    vectors++; if (hi2 !== 32'h0) begin miscompares++; $display("FAIL div_min_rem got %h want 00000000", hi2); end
    vectors++; if (dbz2 !== 1'b0) begin miscompares++; $display("FAIL div_min_flag got %b want 0", dbz2); end
  endtask

  task automatic test_madd_msub;
    int lat, nb; logic bd;
    start_op(MULDIV_MADDU, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h1);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 18) begin miscompares++; $display("FAIL maddu_latency got %0d want 18", lat); end
    vectors++; if (hi2 !== 32'h1) begin miscompares++; $display("FAIL maddu_hi got %h want 00000001", hi2); end
    vectors++; if (lo2 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL maddu_lo got %h want FFFFFFFF", lo2); end
    start_op(MULDIV_MSUB, 32'h3, 32'h4, 32'h0, 32'hA);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 18) begin miscompares++; $display("FAIL msub_latency got %0d want 18", lat); end
    vectors++; if (lo2 !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL msub_lo got %h want FFFFFFFE", lo2); end
    vectors++; if (hi2 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL msub_hi got %h want FFFFFFFF", hi2); end
  endtask

  task automatic test_start_while_busy;
    int lat, nb; logic bd;
    start_op(MULDIV_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    // Competing requests in cycles 2-9 must not re-latch operands.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        start = 1'b1; op = MULDIV_MULT; src1 = 32'd9; src2 = 32'd9;
      end
      @(posedge clk);
    end
    #1 start = 1'b0;
    wait_ready(10, lat, nb, bd);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL busy_start_latency got %0d want 33", lat); end
    vectors++; if (lo2 !== 32'd14) begin miscompares++; $display("FAIL busy_start_quo got %h want 0000000E", lo2); end
    vectors++; if (hi2 !== 32'd2) begin miscompares++; $display("FAIL busy_start_rem got %h want 00000002", hi2); end
  endtask

  task automatic test_annul;
    int lat, nb; logic bd; logic seen_ready;
    seen_ready = 1'b0;
    start_op(MULDIV_DIV, 32'h64, 32'h3, 32'h0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready2 !== 1'b0) seen_ready = 1'b1;
      if (k == 10) annul = 1'b1;
      @(posedge clk);
    end
    #1 annul = 1'b0;
    vectors++; if (seen_ready !== 1'b0) begin miscompares++; $display("FAIL annul_early_ready got %b want 0", seen_ready); end
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL annul_busy got %b want 0", busy2); end
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL annul_ready got %b want 0", ready2); end
    vectors++; if (lo2 !== 32'd14) begin miscompares++; $display("FAIL annul_lo_hold got %h want 0000000E", lo2); end
    vectors++; if (hi2 !== 32'd2) begin miscompares++; $display("FAIL annul_hi_hold got %h want 00000002", hi2); end
    // Request in cycle 11 must be accepted.
    start_op(MULDIV_DIVU, 32'h1000, 32'h10, 32'h0, 32'h0);
    wait_ready(1, lat, nb, bd);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL annul_restart_latency got %0d want 33", lat); end
    vectors++; if (lo2 !== 32'h100) begin miscompares++; $display("FAIL annul_restart_quo got %h want 00000100", lo2); end
    vectors++; if (hi2 !== 32'h0) begin miscompares++; $display("FAIL annul_restart_rem got %h want 00000000", hi2); end
  endtask

  task automatic test_async_reset;
    start_op(MULDIV_MULT, 32'h3, 32'h3, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy2 !== 1'b1) begin miscompares++; $display("FAIL arst_busy_before got %b want 1", busy2); end
    #1 rst = 1'b0;
    #1;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL arst_busy got %b want 0", busy2); end
    vectors++; if (ready2 !== 1'b0) begin miscompares++; $display("FAIL arst_ready got %b want 0", ready2); end
    vectors++; if (hi2 !== 32'h0) begin miscompares++; $display("FAIL arst_hi got %h want 0", hi2); end
    vectors++; if (lo2 !== 32'h0) begin miscompares++; $display("FAIL arst_lo got %h want 0", lo2); end
    vectors++; if (dbz2 !== 1'b0) begin miscompares++; $display("FAIL arst_dbz got %b want 0", dbz2); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_mul_step;
    int lat1, lat2, lat4;
    lat1 = -1; lat2 = -1; lat4 = -1;
    start_op(MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ready1 === 1'b1 && lat1 < 0) lat1 = k;
      if (ready2 === 1'b1 && lat2 < 0) lat2 = k;
      if (ready4 === 1'b1 && lat4 < 0) lat4 = k;
    end
    vectors++; if (lat2 !== 17) begin miscompares++; $display("FAIL step2_latency got %0d want 17", lat2); end
    vectors++; if (lat1 !== 33) begin miscompares++; $display("FAIL step1_latency got %0d want 33", lat1); end
    vectors++; if (lat4 !== 9) begin miscompares++; $display("FAIL step4_latency got %0d want 9", lat4); end
    vectors++; if ({hi2, lo2} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL step2_product got %h want FFFFFFFE00000001", {hi2, lo2}); end
    vectors++; if ({hi1, lo1} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL step1_product got %h want FFFFFFFE00000001", {hi1, lo1}); end
    vectors++; if ({hi4, lo4} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL step4_product got %h want FFFFFFFE00000001", {hi4, lo4}); end
    vectors++; if ((dbz1 | dbz4) !== 1'b0) begin miscompares++; $display("FAIL step_dbz got %b want 0", dbz1 | dbz4); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; annul = 1'b0; op = 3'd0;
    src1 = '0; src2 = '0; hi_i = '0; lo_i = '0;
    test_reset;
    test_mult;
    test_div_by_zero;
    test_div;
    test_madd_msub;
    test_start_while_busy;
    test_annul;
    test_async_reset;
    test_mul_step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
